// File: rtl/wb_burst_master_pkg.sv
`default_nettype none
// ============================================================================
// wb_burst_master_pkg : shared Wishbone B3 tag codes and master FSM states
// Revision: 1.0
// ============================================================================
package wb_burst_master_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_master_timeout.sv
`default_nettype none
// ============================================================================
// wb_master_timeout : stall counter, expires on the TIMEOUT-th enabled cycle
// Revision: 1.0
// ============================================================================
module wb_master_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_enabled
      localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

      logic [W-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (load) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= cnt + 1'b1;
        end
      end

      // Fires during the stalled cycle that completes the budget.
      assign expired = en & (cnt == LAST);
    end else begin : g_disabled
      assign expired = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// wb_burst_master : command/stream to Wishbone B3 classic and linear bursts
// Revision: 1.0
// ============================================================================
module wb_burst_master
  import wb_burst_master_pkg::*;
#(
  parameter int          LEN_BITS  = 8,
  parameter int          TIMEOUT   = 255,
  parameter logic [2:0]  BURST_CTI = CTI_INCR,
  parameter logic [1:0]  BURST_BTE = BTE_LINEAR,
  parameter logic [2:0]  END_CTI   = CTI_END
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [29:0]         cmd_addr,
  input  logic [LEN_BITS-1:0] cmd_len,
  input  logic                wr_valid,
  input  logic [31:0]         wr_data,
  output logic                wr_ready,
  output logic                rd_valid,
  output logic [31:0]         rd_data,
  output logic                done,
  output logic                err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic [29:0]         wbm_addr_o,
  output logic [2:0]          wbm_cti_o,
  output logic [1:0]          wbm_bte_o,
  output logic [3:0]          wbm_sel_o,
  output logic                wbm_we_o,
  output logic [31:0]         wbm_data_o,
  input  logic [31:0]         wbm_data_i,
  input  logic                wbm_ack_i
);

  state_t              state;
  logic                cyc_r;
  logic                we_r;
  logic                single_r;
  logic [29:0]         addr_r;
  logic [LEN_BITS-1:0] left_r;

  logic stb;
  logic ack_ok;
  logic last_beat;
  logic accept;
  logic expired;

  // Write beats hold stb low while the client stream is empty.
  assign stb       = cyc_r & (~we_r | wr_valid);
  assign ack_ok    = stb & wbm_ack_i;
  assign last_beat = (left_r == LEN_BITS'(1));
  assign accept    = (state == ST_IDLE) & cmd_valid;

  assign cmd_ready  = (state == ST_IDLE);
  assign wr_ready   = we_r & ack_ok;
  assign wbm_cyc_o  = cyc_r;
  assign wbm_stb_o  = stb;
  assign wbm_addr_o = addr_r;
  assign wbm_we_o   = cyc_r & we_r;
  assign wbm_data_o = wr_data;
  assign wbm_sel_o  = SEL_WORD;
  assign wbm_bte_o  = BURST_BTE;
  assign wbm_cti_o  = (!cyc_r || single_r) ? CTI_CLASSIC :
                      (last_beat ? END_CTI : BURST_CTI);

  wb_master_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept | ack_ok),
    .en      (stb & ~wbm_ack_i),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cyc_r    <= 1'b0;
      we_r     <= 1'b0;
      single_r <= 1'b0;
      addr_r   <= '0;
      left_r   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            we_r     <= cmd_we;
            addr_r   <= cmd_addr;
            left_r   <= cmd_len;
            single_r <= (cmd_len == LEN_BITS'(1));
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_BUS;
              cyc_r <= 1'b1;
            end
          end
        end
        ST_BUS: begin
          if (ack_ok) begin
            addr_r <= addr_r + 30'd1;
            left_r <= left_r - LEN_BITS'(1);
            if (!we_r) begin
              rd_valid <= 1'b1;
              rd_data  <= wbm_data_i;
            end
            if (last_beat) begin
              state <= ST_IDLE;
              cyc_r <= 1'b0;
              done  <= 1'b1;
            end
          end else if (expired) begin
            state <= ST_IDLE;
            cyc_r <= 1'b0;
            err   <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cyc_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Wishbone master (initiator) that turns a simple command/stream interface into Wishbone B3 transfers on the system bus. Multi-word commands are issued as incrementing linear bursts (sel 4'b1111, CTI/BTE tags). Single-word commands are issued as classic cycles. Used by DMA-style clients (display fetch, block copy) to drive wishbone slaves such as the SRAM/PSRAM controllers.

Parameters:
LEN_BITS, 8, width of cmd_len; max burst = 2^LEN_BITS-1 words
TIMEOUT, 255, cycles with stb high and no ack before abort; 0 disables timeout
BURST_CTI, 3'b010, CTI for non-final burst beats (incrementing)
BURST_BTE, 2'b00, BTE for bursts (linear)
END_CTI, 3'b111, CTI on final beat of a burst

Ports:
clk  in  1  single clock; bus and client side
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_we  in  1  1=write, 0=read
cmd_addr  in  30  start word address [31:2]
cmd_len  in  LEN_BITS  word count
wr_valid  in  1  write data available
wr_data  in  32  write word
wr_ready  out  1  write word consumed this cycle
rd_valid  out  1  read word valid, one-cycle pulse, no backpressure
rd_data  out  32  read word
done  out  1  one-cycle pulse, command completed normally
err  out  1  one-cycle pulse, command aborted by timeout
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_addr_o  out  30  word address [31:2]
wbm_cti_o  out  3  cycle type identifier
wbm_bte_o  out  2  burst type extension
wbm_sel_o  out  4  byte selects, constant 4'b1111
wbm_we_o  out  1  write enable
wbm_data_o  out  32  write data
wbm_data_i  in  32  read data
wbm_ack_i  in  1  slave acknowledge

Behaviour:
- Reset (async, rst_n low): state=IDLE; cyc, stb, we, rd_valid, done, err=0; addr, counters, rd_data=0; cti=000; bte=BURST_BTE. Bus is released in the same instant reset asserts, including mid-burst.
- States: IDLE, BUS.
- IDLE: cmd_ready=1. On cmd_valid, latch we/addr/len into registers (addr_r, left_r, single_r = (cmd_len==1)).
  - cmd_len==0: stay in IDLE, pulse done next cycle, no bus activity.
  - Otherwise: go to BUS. cyc rises the cycle after acceptance.
- BUS outputs:
  - wbm_cyc_o=1; wbm_addr_o=addr_r; wbm_we_o=we_r.
  - wbm_stb_o = ~we_r | wr_valid. Write beats insert wait states while the stream is empty.
  - wbm_data_o=wr_data; wr_ready = we_r & wbm_ack_i.
  - cti = single_r ? 3'b000 : (left_r==1 ? END_CTI : BURST_CTI).
- ack handling (only counted while stb high): addr_r+=1 (30-bit wrap, no error), left_r-=1.
  - Read: rd_data<=wbm_data_i and rd_valid=1 for exactly one cycle, the cycle after the ack.
  - ack with left_r==1: go to IDLE; cyc/stb drop the next cycle; done pulses the next cycle (aligned with the last rd_valid).
- Back-to-back commands: cmd_ready returns one cycle after the final ack. Minimum one idle bus cycle between commands.
- Timeout: counter resets on every ack and on BUS entry, and counts while stb=1 & ack=0. Reaching TIMEOUT aborts: go to IDLE, drop cyc, pulse err. Remaining words are discarded and done does not pulse. Counter does not run while stb is low (write stall).
- ack while stb=0 is ignored (protocol violation tolerated).
- Throughput: one word per clock when the slave acks every cycle and wr_valid stays high.

Decomposition:
- Shared package/define header: CTI codes (CLASSIC=000, INCR=010, END=111), BTE_LINEAR=00, state encodings.
- One natural sub-module: wb_master_timeout (load/enable/expire counter), reusable by other masters.
- Datapath and FSM stay in this module.

Test Plan:
- Single read: cmd addr=0x100, len=1, slave acks on 2nd stb cycle with 0xDEADBEEF → cti=000, one ack, rd_data=0xDEADBEEF, rd_valid and done on the same cycle.
- 4-word read burst at 0x3FFFFFFE, slave acks every cycle → addrs 3FFFFFFE, 3FFFFFFF, 00000000, 00000001; cti 010, 010, 010, 111; bte 00; 4 rd_valid; cyc high exactly 4 cycles.
- 3-word write with wr_valid low for 2 cycles before beat 2 → stb low during the gap, no timeout, wr_ready pulses 3 times, slave receives words in order, done once.
- cmd_len=0 → no cyc ever asserted, done pulse one cycle after acceptance, cmd_ready high again.
- TIMEOUT=8, slave never acks → err after 8 stalled cycles, cyc drops, no done, next command accepted normally.
- rst_n pulled low mid-burst on beat 2 → cyc/stb drop immediately; after release: IDLE, cmd_ready=1, no done/err.
